// File: rtl/drain_sched.sv
// drain_sched: queues tile drain commands and hands each tile to the output
// controller. Each tile gets a contiguous region of the 256-row output buffer
// taken from a circular write pointer. A credit counter tracks free rows, and
// the downstream consumer returns rows to that counter.
//
// state | meaning
// IDLE  | waiting for a queued command (head is only peeked)
// CHECK | validate head row count and wait for enough free-row credit
// ISSUE | tile allocated; start pulse goes out next cycle
// ARM   | start pulse on the wire; controller done still stale, ignored
// WAIT  | waiting for the output controller to report done
module drain_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_num_row,
    input  logic                  cmd_last,
    output logic                  oc_en,
    output logic [7:0]            oc_base_addr,
    output logic [DATA_WIDTH-1:0] oc_num_row,
    input  logic                  oc_done,
    input  logic                  free_valid,
    input  logic [8:0]            free_rows,
    output logic [8:0]            free_cnt,
    output logic                  busy,
    output logic                  layer_done,
    output logic                  err
);

    localparam int OUT_ROWS = 256;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, ARM, WAIT} state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr_q;
    logic [CNT_W-1:0]      count, count_n;
    logic [7:0]            wr_ptr;
    logic                  last_q;

    logic                  push, pop, alloc, err_chk, ld_set;
    logic [DATA_WIDTH-1:0] head_num;
    logic                  head_last;
    logic                  bad_row, fits;
    logic [9:0]            add_rows, sub_rows, credit_sum;
    logic [8:0]            free_n;
    logic                  err_free;

    assign push      = cmd_valid && cmd_ready;
    assign head_num  = fifo_mem[rd_ptr][DATA_WIDTH-1:0];
    assign head_last = fifo_mem[rd_ptr][DATA_WIDTH];
    assign bad_row   = (head_num == '0) || (head_num > DATA_WIDTH'(OUT_ROWS));
    assign fits      = DATA_WIDTH'(free_cnt) >= head_num;
    assign count_n   = count + CNT_W'(push) - CNT_W'(pop);

    // Next-state and per-cycle control decode
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        alloc   = 1'b0;
        err_chk = 1'b0;
        ld_set  = 1'b0;
        case (state)
            IDLE:  if (count != '0) state_n = CHECK;
            CHECK: begin
                if (bad_row) begin
                    pop     = 1'b1;
                    err_chk = 1'b1;
                    ld_set  = head_last;
                    state_n = IDLE;
                end else if (fits) begin
                    pop     = 1'b1;
                    alloc   = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: state_n = ARM;
            ARM:   state_n = WAIT;
            WAIT: begin
                if (oc_done) begin
                    ld_set  = last_q;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Credit arithmetic: allocation and release may land in the same cycle
    always_comb begin
        add_rows   = (free_valid && free_rows != '0) ? {1'b0, free_rows} : 10'd0;
        sub_rows   = alloc ? head_num[9:0] : 10'd0;
        credit_sum = {1'b0, free_cnt} + add_rows - sub_rows;
        err_free   = free_valid && ((free_rows == '0) || (credit_sum > 10'd256));
        free_n     = (credit_sum > 10'd256) ? 9'd256 : credit_sum[8:0];
    end

    // Command storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {cmd_last, cmd_num_row};
    end

    // FSM, queue bookkeeping, allocation and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            rd_ptr       <= '0;
            wr_ptr_q     <= '0;
            count        <= '0;
            cmd_ready    <= 1'b1;
            wr_ptr       <= 8'd0;
            last_q       <= 1'b0;
            free_cnt     <= 9'd256;
            oc_en        <= 1'b0;
            oc_base_addr <= 8'd0;
            oc_num_row   <= '0;
            busy         <= 1'b0;
            layer_done   <= 1'b0;
            err          <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            cmd_ready  <= count_n != CNT_W'(FIFO_DEPTH);
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr   <= rd_ptr + 1'b1;
            free_cnt   <= free_n;
            if (alloc) begin
                oc_base_addr <= wr_ptr;
                oc_num_row   <= head_num;
                last_q       <= head_last;
                wr_ptr       <= wr_ptr + head_num[7:0];
            end
            oc_en      <= (state == ISSUE);
            busy       <= (count_n != '0) || (state_n != IDLE);
            layer_done <= ld_set;
            err        <= err | err_chk | err_free;
        end
    end

endmodule
